// File: rtl/frame_pkg.sv
// Shared definitions for the display frame sequencer: effect modes, scan limits
// and control-register field positions.
package frame_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_SCROLL_L = 2'd1,
    MODE_SCROLL_U = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  localparam logic [5:0] CHARLIE_LAST = 6'd63;

  localparam int CTRL_MODE_LSB   = 0;
  localparam int CTRL_INVERT_BIT = 2;
  localparam int CTRL_FREEZE_BIT = 3;
  localparam int CTRL_SPEED_LSB  = 4;

endpackage

// File: rtl/frame_transform.sv
// Combinational effect stage: scroll/blink/invert applied to the active frame.
// Row r lives in bits [8r+7:8r]; pixel (r,c) is therefore bit index {r,c}.
module frame_transform
  import frame_pkg::*;
(
  input  logic [63:0] active,
  input  mode_e       mode,
  input  logic [2:0]  offset,
  input  logic        blink_phase,
  input  logic        invert,
  output logic [63:0] frame
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      for (gj = 0; gj < 8; gj++) begin : g_col
        localparam logic [2:0] ROW = 3'(gi);
        localparam logic [2:0] COL = 3'(gj);
        logic [2:0] col_l;
        logic [2:0] row_u;
        logic       px;

        // 3-bit sums wrap mod 8 for free
        assign col_l = COL + offset;
        assign row_u = ROW + offset;

        always_comb begin
          px = active[{ROW, COL}];
          case (mode)
            MODE_SCROLL_L: px = active[{ROW, col_l}];
            MODE_SCROLL_U: px = active[{row_u, COL}];
            MODE_BLINK:    px = active[{ROW, COL}] & ~blink_phase;
            default:       px = active[{ROW, COL}];
          endcase
        end

        assign frame[gi*8+gj] = px ^ invert;
      end
    end
  endgenerate

endmodule

// File: rtl/frame_sequencer.sv
// Tear-free frame sequencer: buffers SPI commits, promotes them only on the
// 63->0 scan wrap, steps display effects per frame and registers the result.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int SPEED_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] shadow_frame,
  input  logic        commit,
  input  logic [7:0]  ctrl,
  input  logic [5:0]  charlie_index,
  output logic [63:0] frame_out,
  output logic        frame_tick,
  output logic        pending,
  output logic [7:0]  status
);

  logic [5:0]         prev_index_q;
  logic [63:0]        active_q, active_d;
  logic [63:0]        pend_buf_q, pend_buf_d;
  logic               pending_q, pending_d;
  mode_e              mode_q, mode_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               invert_q, invert_d;
  logic [2:0]         offset_q, offset_d;
  logic [SPEED_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               frame_tick_q;
  logic [63:0]        frame_out_q;
  logic [63:0]        xform_frame;

  logic               boundary;
  mode_e              ctrl_mode;
  logic [SPEED_W-1:0] ctrl_speed;

  assign boundary   = (charlie_index == 6'd0) && (prev_index_q == CHARLIE_LAST);
  assign ctrl_mode  = mode_e'(ctrl[CTRL_MODE_LSB +: 2]);
  assign ctrl_speed = ctrl[CTRL_SPEED_LSB +: SPEED_W];

  always_comb begin
    active_d      = active_q;
    pend_buf_d    = pend_buf_q;
    pending_d     = pending_q;
    mode_d        = mode_q;
    speed_d       = speed_q;
    invert_d      = invert_q;
    offset_d      = offset_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    if (boundary) begin
      // A commit landing on the boundary itself bypasses the pending buffer
      if (commit) begin
        active_d = shadow_frame;
      end else if (pending_q) begin
        active_d = pend_buf_q;
      end
      pending_d = 1'b0;

      mode_d   = ctrl_mode;
      speed_d  = ctrl_speed;
      invert_d = ctrl[CTRL_INVERT_BIT];
      if (ctrl_mode != mode_q) begin
        offset_d      = 3'd0;
        frame_cnt_d   = '0;
        blink_phase_d = 1'b0;
      end

      if (!ctrl[CTRL_FREEZE_BIT]) begin
        if (frame_cnt_d == speed_d) begin
          frame_cnt_d = '0;
          case (mode_d)
            MODE_SCROLL_L, MODE_SCROLL_U: offset_d = offset_d + 3'd1;
            MODE_BLINK:                   blink_phase_d = ~blink_phase_d;
            default:                      ;
          endcase
        end else begin
          frame_cnt_d = frame_cnt_d + 1'b1;
        end
      end
    end else if (commit) begin
      pend_buf_d = shadow_frame;
      pending_d  = 1'b1;
    end
  end

  frame_transform u_transform (
    .active      (active_q),
    .mode        (mode_q),
    .offset      (offset_q),
    .blink_phase (blink_phase_q),
    .invert      (invert_q),
    .frame       (xform_frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_index_q  <= 6'd0;
      active_q      <= '0;
      pend_buf_q    <= '0;
      pending_q     <= 1'b0;
      mode_q        <= MODE_STATIC;
      speed_q       <= '0;
      invert_q      <= 1'b0;
      offset_q      <= 3'd0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_out_q   <= '0;
    end else begin
      prev_index_q  <= charlie_index;
      active_q      <= active_d;
      pend_buf_q    <= pend_buf_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      speed_q       <= speed_d;
      invert_q      <= invert_d;
      offset_q      <= offset_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= boundary;
      frame_out_q   <= xform_frame;
    end
  end

  assign frame_out  = frame_out_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;
  assign status     = {pending_q, blink_phase_q, mode_q, 1'b0, offset_q};

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: the driver runs a frame-level reference
// model and queues expected displays; a monitor checks them after each frame_tick.
module tb_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic [63:0] shadow_frame;
  logic        commit;
  logic [7:0]  ctrl;
  logic [5:0]  charlie_index;
  logic [63:0] frame_out;
  logic        frame_tick;
  logic        pending;
  logic [7:0]  status;

  frame_sequencer #(.SPEED_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .shadow_frame  (shadow_frame),
    .commit        (commit),
    .ctrl          (ctrl),
    .charlie_index (charlie_index),
    .frame_out     (frame_out),
    .frame_tick    (frame_tick),
    .pending       (pending),
    .status        (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fr;
    logic [7:0]  st;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [63:0] m_active, m_pbuf;
  bit          m_pend;
  int          m_prev, m_mode, m_spd, m_cnt, m_off, m_ph, m_inv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  function automatic logic [63:0] xform(input logic [63:0] a, input int mode, input int off,
                                        input int ph, input int inv);
    logic [63:0] res;
    int s;
    logic b;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (mode == 1)      s = r * 8 + (c + off) % 8;
        else if (mode == 2) s = ((r + off) % 8) * 8 + c;
        else                s = r * 8 + c;
        b = a[s];
        if (mode == 3 && ph != 0) b = 1'b0;
        if (inv != 0) b = ~b;
        res[r*8+c] = b;
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    m_active = '0; m_pbuf = '0; m_pend = 0;
    m_prev = 0; m_mode = 0; m_spd = 0; m_cnt = 0; m_off = 0; m_ph = 0; m_inv = 0;
  endtask

  // One clock cycle of stimulus; called right after a falling edge.
  task automatic cyc(input int idx, input bit cm, input logic [63:0] fr);
    bit   bnd;
    int   nm;
    exp_t e;
    logic [7:0] cv;
    charlie_index = idx[5:0];
    commit        = cm;
    shadow_frame  = fr;
    cv            = ctrl;
    bnd = (idx == 0) && (m_prev == 63);
    if (bnd) begin
      if (cm) m_active = fr;
      else if (m_pend) m_active = m_pbuf;
      m_pend = 0;
      nm = int'(cv[1:0]);
      if (nm != m_mode) begin
        m_off = 0; m_cnt = 0; m_ph = 0;
      end
      m_mode = nm;
      m_spd  = int'(cv[7:4]);
      m_inv  = int'(cv[2]);
      if (!cv[3]) begin
        if (m_cnt == m_spd) begin
          m_cnt = 0;
          if (m_mode == 1 || m_mode == 2) m_off = (m_off + 1) % 8;
          if (m_mode == 3) m_ph = 1 - m_ph;
        end else begin
          m_cnt++;
        end
      end
      e.fr = xform(m_active, m_mode, m_off, m_ph, m_inv);
      e.st = {1'b0, m_ph[0], m_mode[1:0], 1'b0, m_off[2:0]};
      sb_q.push_back(e);
    end else if (cm) begin
      m_pbuf = fr;
      m_pend = 1;
    end
    m_prev = idx;
    @(posedge clk);
    @(negedge clk);
    commit = 1'b0;
    chk("pending", {63'd0, pending}, {63'd0, m_pend});
    chk("frame_tick", {63'd0, frame_tick}, {63'd0, bnd});
  endtask

  // Fast frame: 63 then 0 gives a boundary every two cycles.
  task automatic boundary(input bit cm, input logic [63:0] fr);
    cyc(63, 0, '0);
    cyc(0, cm, fr);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got frame_out %h, expected no display update", frame_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("frame_out", frame_out, e.fr);
        chk("status", {56'd0, status & 8'h7F}, {56'd0, e.st});
      end
    end
  end

  initial begin
    logic [7:0] rc;
    int ri;
    rst_n = 1'b0; commit = 1'b0; ctrl = 8'h00; shadow_frame = '0; charlie_index = 6'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_frame_out", frame_out, 64'd0);
    chk("rst_status", {56'd0, status}, 64'd0);
    chk("rst_pending", {63'd0, pending}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // commit mid-frame, promoted at the 63->0 wrap
    for (int i = 0; i < 10; i++) cyc(i, 0, '0);
    cyc(10, 1, 64'h0123_4567_89AB_CDEF);
    for (int i = 11; i < 64; i++) cyc(i, 0, '0);
    cyc(0, 0, '0);
    cyc(1, 0, '0);
    cyc(2, 0, '0);

    // non-boundary jumps
    cyc(62, 0, '0); cyc(0, 0, '0); cyc(63, 0, '0); cyc(5, 0, '0);

    // commit in the boundary cycle, then two commits in one frame
    boundary(1, 64'hDEAD_BEEF_0000_1111);
    cyc(7, 1, 64'hAAAA_AAAA_AAAA_AAAA);
    cyc(8, 1, 64'h5555_0000_5555_0000);
    boundary(0, '0);

    // scroll-left, speed 0, row0 = 01, nine wraps
    ctrl = 8'h00;
    boundary(1, 64'h0000_0000_0000_0001);
    ctrl = 8'h01;
    repeat (9) boundary(0, '0);

    // blink speed 1 on all-ones, then freeze
    ctrl = 8'h13;
    boundary(1, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (5) boundary(0, '0);
    ctrl = 8'h1B;
    repeat (4) boundary(0, '0);

    // scroll-up + invert with row0 = FF
    ctrl = 8'h06;
    boundary(1, 64'h0000_0000_0000_00FF);
    cyc(1, 0, '0); cyc(2, 0, '0);
    // mid-frame ctrl change must not alter the display
    ctrl = 8'h03;
    cyc(3, 0, '0); cyc(4, 0, '0); cyc(5, 0, '0);
    chk("hold_midframe", frame_out, xform(m_active, m_mode, m_off, m_ph, m_inv));
    boundary(0, '0);
    cyc(1, 0, '0); cyc(2, 0, '0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if (m_prev == 63 && ($urandom % 4) != 0) ri = 0;
      else if (($urandom % 3) == 0) ri = 63;
      else ri = int'($urandom_range(0, 63));
      if (($urandom % 20) == 0) begin
        rc = 8'($urandom);
        rc[7:4] = 4'($urandom_range(0, 2));
        rc[3] = (($urandom % 4) == 0);
        ctrl = rc;
      end
      cyc(ri, (($urandom % 8) == 0), {$urandom, $urandom});
    end
    cyc(1, 0, '0); cyc(2, 0, '0); cyc(3, 0, '0);

    // async reset mid-frame discards a pending frame
    ctrl = 8'h00;
    cyc(5, 1, 64'hCAFE_F00D_1234_5678);
    cyc(6, 0, '0); cyc(7, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_frame_out", frame_out, 64'd0);
    chk("async_rst_pending", {63'd0, pending}, 64'd0);
    chk("async_rst_status", {56'd0, status}, 64'd0);
    chk("async_rst_tick", {63'd0, frame_tick}, 64'd0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(0, 0, '0);
    boundary(0, '0);
    cyc(1, 0, '0); cyc(2, 0, '0); cyc(3, 0, '0);

    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d undisplayed frames, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
